// File: rtl/sensor_monitor.sv
// Debounced sensor fault monitor: synchronizes raw sensor levels, qualifies the
// fault condition over DEBOUNCE_CYCLES samples and records entry snapshots/counts.
module sensor_monitor #(
  parameter int NUM_SENSORS     = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic                   latch_en,
  input  logic                   clear,
  output logic                   error,
  output logic                   pending,
  output logic [NUM_SENSORS-1:0] fault_snap,
  output logic [CNT_WIDTH-1:0]   fault_count
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_PENDING = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic [7:0]           DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam bit                   DEB_ONE  = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [NUM_SENSORS-1:0] sync1_r;
  logic [NUM_SENSORS-1:0] s_sync_r;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [7:0]             dcnt_r;
  logic [7:0]             dcnt_nxt_s;
  logic                   raw_s;
  logic                   entry_s;
  logic                   error_r;
  logic                   pending_r;
  logic [NUM_SENSORS-1:0] snap_r;
  logic [NUM_SENSORS-1:0] snap_nxt_s;
  logic [CNT_WIDTH-1:0]   count_r;
  logic [CNT_WIDTH-1:0]   count_nxt_s;

  assign raw_s = s_sync_r[0] | (s_sync_r[1] & (|s_sync_r[NUM_SENSORS-1:2]));

  // Next-state and debounce counter; clear only acts when raw has already dropped.
  always_comb begin
    state_nxt_s = state_r;
    dcnt_nxt_s  = dcnt_r;
    case (state_r)
      ST_OK: begin
        if (raw_s) begin
          if (DEB_ONE) begin
            state_nxt_s = ST_FAULT;
            dcnt_nxt_s  = 8'd0;
          end else begin
            state_nxt_s = ST_PENDING;
            dcnt_nxt_s  = 8'd1;
          end
        end else begin
          state_nxt_s = ST_OK;
          dcnt_nxt_s  = 8'd0;
        end
      end
      ST_PENDING: begin
        if (!raw_s) begin
          state_nxt_s = ST_OK;
          dcnt_nxt_s  = 8'd0;
        end else if (dcnt_r == DEB_LAST) begin
          state_nxt_s = ST_FAULT;
          dcnt_nxt_s  = 8'd0;
        end else begin
          dcnt_nxt_s  = dcnt_r + 8'd1;
        end
      end
      ST_FAULT: begin
        if (raw_s) begin
          state_nxt_s = ST_FAULT;
          dcnt_nxt_s  = 8'd0;
        end else if (latch_en) begin
          if (clear) begin
            state_nxt_s = ST_OK;
            dcnt_nxt_s  = 8'd0;
          end else begin
            state_nxt_s = ST_FAULT;
            dcnt_nxt_s  = 8'd0;
          end
        end else if (DEB_ONE) begin
          state_nxt_s = ST_OK;
          dcnt_nxt_s  = 8'd0;
        end else begin
          state_nxt_s = ST_RECOVER;
          dcnt_nxt_s  = 8'd1;
        end
      end
      ST_RECOVER: begin
        if (raw_s) begin
          state_nxt_s = ST_FAULT;
          dcnt_nxt_s  = 8'd0;
        end else if (clear || (dcnt_r == DEB_LAST)) begin
          state_nxt_s = ST_OK;
          dcnt_nxt_s  = 8'd0;
        end else begin
          dcnt_nxt_s  = dcnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_OK;
        dcnt_nxt_s  = 8'd0;
      end
    endcase
  end

  // Entry bookkeeping: a return from RECOVER is not a new entry; entry beats clear.
  always_comb begin
    entry_s     = ((state_r == ST_OK) || (state_r == ST_PENDING)) && (state_nxt_s == ST_FAULT);
    snap_nxt_s  = snap_r;
    count_nxt_s = count_r;
    if (entry_s) begin
      snap_nxt_s = s_sync_r;
      if (clear) begin
        count_nxt_s = CNT_ONE;
      end else if (count_r == CNT_MAX) begin
        count_nxt_s = count_r;
      end else begin
        count_nxt_s = count_r + CNT_ONE;
      end
    end else if (clear) begin
      snap_nxt_s  = {NUM_SENSORS{1'b0}};
      count_nxt_s = {CNT_WIDTH{1'b0}};
    end else begin
      snap_nxt_s  = snap_r;
      count_nxt_s = count_r;
    end
  end

  // State, synchronizer and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_r   <= {NUM_SENSORS{1'b0}};
      s_sync_r  <= {NUM_SENSORS{1'b0}};
      state_r   <= ST_OK;
      dcnt_r    <= 8'd0;
      error_r   <= 1'b0;
      pending_r <= 1'b0;
      snap_r    <= {NUM_SENSORS{1'b0}};
      count_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      sync1_r   <= sensors;
      s_sync_r  <= sync1_r;
      state_r   <= state_nxt_s;
      dcnt_r    <= dcnt_nxt_s;
      error_r   <= (state_nxt_s == ST_FAULT) || (state_nxt_s == ST_RECOVER);
      pending_r <= (state_nxt_s == ST_PENDING);
      snap_r    <= snap_nxt_s;
      count_r   <= count_nxt_s;
    end
  end

  assign error       = error_r;
  assign pending     = pending_r;
  assign fault_snap  = snap_r;
  assign fault_count = count_r;

endmodule
